// File: rtl/axi_burst_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_burst_slave
// Brief    : AXI INCR-burst memory slave, byte strobes, SLVERR on out-of-range
//            beats, independent write/read FSMs over one flop-based memory.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH + 1;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] c_DEPTH = IDX_W'(DEPTH);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ---------------------------------------------------------------- write
    wstate_t          r_wstate, w_wstate_nxt;
    logic             r_awready;
    logic [IDX_W-1:0] r_widx;
    logic [7:0]       r_wlen, r_wcnt;
    logic             r_werr;
    logic             w_aw_hs, w_w_hs, w_wlast_beat, w_widx_ok;

    assign w_aw_hs      = awvalid && r_awready;
    assign w_w_hs       = wvalid && (r_wstate == W_DATA);
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_widx_ok    = (r_widx < c_DEPTH);
    assign awready      = r_awready;

    always_comb begin
        w_wstate_nxt = r_wstate;
        wready       = 1'b0;
        bvalid       = 1'b0;
        bresp        = 2'b00;
        case (r_wstate)
            W_IDLE: if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA: begin
                wready = 1'b1;
                if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = r_werr ? 2'b10 : 2'b00;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // awready is registered so it reads 0 throughout reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            if (w_aw_hs) begin
                r_widx <= {1'b0, awaddr} >> SHIFT;
                r_wlen <= awlen;
                r_wcnt <= '0;
                r_werr <= 1'b0;
            end else if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                r_wcnt <= r_wcnt + 1'b1;
                if (!w_widx_ok || (wlast != w_wlast_beat)) r_werr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && w_widx_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) r_mem[r_widx[MEM_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_arready;
    logic [IDX_W-1:0]      r_ridx, w_rload_idx;
    logic [7:0]            r_rlen, r_rcnt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rload_data;
    logic [1:0]            r_rresp, w_rload_resp;
    logic                  w_ar_hs, w_r_hs, w_rlast_beat;

    assign w_ar_hs      = arvalid && r_arready;
    assign w_r_hs       = rready && (r_rstate == R_DATA);
    assign w_rlast_beat = (r_rcnt == r_rlen);
    assign w_rload_idx  = w_ar_hs ? ({1'b0, araddr} >> SHIFT) : (r_ridx + 1'b1);
    assign arready      = r_arready;
    assign rdata        = r_rdata;
    assign rresp        = r_rresp;

    // Beat data is captured at the edge that presents it, so it stays stable
    // under back-pressure and a same-cycle write is seen only by later beats.
    always_comb begin
        w_rload_data = '0;
        w_rload_resp = 2'b10;
        if (w_rload_idx < c_DEPTH) begin
            w_rload_data = r_mem[w_rload_idx[MEM_AW-1:0]];
            w_rload_resp = 2'b00;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        rvalid       = 1'b0;
        rlast        = 1'b0;
        if (r_rstate == R_IDLE) begin
            if (w_ar_hs) w_rstate_nxt = R_DATA;
        end else begin
            rvalid = 1'b1;
            rlast  = w_rlast_beat;
            if (w_r_hs && w_rlast_beat) w_rstate_nxt = R_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_ridx  <= w_rload_idx;
                r_rlen  <= arlen;
                r_rcnt  <= '0;
                r_rdata <= w_rload_data;
                r_rresp <= w_rload_resp;
            end else if (w_r_hs) begin
                if (w_rlast_beat) begin
                    r_rdata <= '0;
                    r_rresp <= 2'b00;
                end else begin
                    r_ridx  <= w_rload_idx;
                    r_rcnt  <= r_rcnt + 1'b1;
                    r_rdata <= w_rload_data;
                    r_rresp <= w_rload_resp;
                end
            end
        end
    end
endmodule
`default_nettype wire
